// File: rtl/seq_pkg.sv
// Shared definitions for the row serializer and the sequence detector bench:
// geometry defaults, serializer state encoding and the row ROM contents.
package seq_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} ser_state_t;

  // Row contents, index 0 first.
  localparam logic [DATA_W-1:0] ROW_DATA [DEPTH] = '{
    16'hA5C3, 16'h1234, 16'h8001, 16'hB3C5, 16'hFFFF, 16'h0000, 16'h5A5A, 16'hC0DE,
    16'h7E81, 16'h0F0F, 16'hF00F, 16'h3C3C, 16'h9669, 16'h1248, 16'h8421, 16'hE71D,
    16'h2B7A, 16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D, 16'h6B2C, 16'h4D91, 16'h0A50,
    16'h5C71, 16'h1357, 16'h2468, 16'hACE1, 16'h0001, 16'h8000, 16'h7FFE, 16'hAAAA
  };

endpackage

// File: rtl/row_rom.sv
// Synchronous-read ROM holding ROW_DATA; one read port, data registered on clk.
module row_rom #(
  parameter int DATA_W = seq_pkg::DATA_W,
  parameter int ADDR_W = seq_pkg::ADDR_W,
  parameter int DEPTH  = seq_pkg::DEPTH
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);
  import seq_pkg::*;

  logic [DATA_W-1:0] mem [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    assign mem[i] = ROW_DATA[i];
  end

  // Registered read; contents are constant so no reset is needed.
  always_ff @(posedge clk) begin
    data <= mem[addr];
  end

endmodule

// File: rtl/row_serializer.sv
// Reads one ROM row at Addr and streams it out one bit per clock with a
// valid qualifier and a sticky end-of-row flag. A new row starts after reset
// release or whenever Addr changes.
// Build option: SER_LSB_FIRST_EN emits each row LSB first (default MSB first).
module row_serializer #(
  parameter int DATA_W = seq_pkg::DATA_W,
  parameter int ADDR_W = seq_pkg::ADDR_W,
  parameter int DEPTH  = seq_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] Addr,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              row_done,
  output logic              busy
);
  import seq_pkg::*;

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
`ifdef SER_LSB_FIRST_EN
  localparam int OUT_IDX = 0;
`else
  localparam int OUT_IDX = DATA_W - 1;
`endif

  ser_state_t        state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] shreg, rom_data;
  logic [CNT_W-1:0]  cnt;
  logic              addr_chg;

  // ROM is addressed straight from Addr so the word for the address latched
  // on the LOAD-entry edge is ready one cycle later.
  row_rom #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_rom (
    .clk  (clk),
    .addr (Addr),
    .data (rom_data)
  );

  assign addr_chg = (Addr != addr_q);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state; an address change reloads ahead of the end-of-row transition.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = LOAD;
      LOAD:    state_nxt = addr_chg ? LOAD : SHIFT;
      SHIFT:   if (addr_chg)             state_nxt = LOAD;
               else if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    if (addr_chg)             state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // Address latch, row load and shift/count datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      shreg  <= '0;
      cnt    <= '0;
    end else begin
      if (state_nxt == LOAD) addr_q <= Addr;
      if (state == LOAD && state_nxt == SHIFT) begin
        shreg <= rom_data;
        cnt   <= '0;
      end else if (state == SHIFT) begin
`ifdef SER_LSB_FIRST_EN
        shreg <= {1'b0, shreg[DATA_W-1:1]};
`else
        shreg <= {shreg[DATA_W-2:0], 1'b0};
`endif
        cnt   <= cnt + CNT_W'(1);
      end
    end
  end

  assign bit_valid = (state == SHIFT);
  assign bit_out   = bit_valid & shreg[OUT_IDX];
  assign row_done  = (state == DONE);
  assign busy      = (state == LOAD) || (state == SHIFT);

endmodule

// File: tb/tb_row_serializer.sv
// Self-checking bench for row_serializer: a row-timeline model checked every
// cycle, plus directed scenarios with hand-computed row words and latencies.
module tb_row_serializer;
  import seq_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [ADDR_W-1:0] Addr = '0;
  logic             bit_out, bit_valid, row_done, busy;

  int n_checks = 0;
  int n_errors = 0;

  // Hand-computed serial words (first emitted bit in the MSB position).
`ifdef SER_LSB_FIRST_EN
  logic [15:0] exp3  = 16'hA3CD;
  logic [15:0] exp24 = 16'h8E3A;
  logic [15:0] exp18 = 16'hF77D;
`else
  logic [15:0] exp3  = 16'hB3C5;
  logic [15:0] exp24 = 16'h5C71;
  logic [15:0] exp18 = 16'hBEEF;
`endif

  row_serializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Addr      (Addr),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .row_done  (row_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: m_age counts edges since the row (re)started; 0 means idle/reset.
  // Row timeline: age 1 load, ages 2..DATA_W+1 carry bits, later ages done.
  int               m_age = 0;
  logic [ADDR_W-1:0] m_addr = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_age  <= 0;
      m_addr <= '0;
    end else if (m_age == 0 || Addr != m_addr) begin
      m_age  <= 1;
      m_addr <= Addr;
    end else if (m_age < 1000) begin
      m_age <= m_age + 1;
    end
  end

  always @(negedge clk) begin : cmp
    logic        ev, eb, ed, ebusy;
    logic [15:0] row;
    int          idx;
    row   = ROW_DATA[m_addr];
    idx   = m_age - 2;
    ev    = (m_age >= 2) && (m_age <= DATA_W + 1);
    ed    = (m_age >= DATA_W + 2);
    ebusy = (m_age >= 1) && (m_age <= DATA_W + 1);
    eb    = 1'b0;
`ifdef SER_LSB_FIRST_EN
    if (ev) eb = row[idx];
`else
    if (ev) eb = row[DATA_W-1-idx];
`endif
    chk("cyc_bit_valid", 32'(bit_valid), 32'(ev));
    chk("cyc_bit_out",   32'(bit_out),   32'(eb));
    chk("cyc_row_done",  32'(row_done),  32'(ed));
    chk("cyc_busy",      32'(busy),      32'(ebusy));
  end

  // Step up to max_steps cycles collecting the stream; stop early once
  // stop_bits bits have been seen (0 = never).
  task automatic run(input int max_steps, input int stop_bits, output logic [15:0] word,
                     output int first, output int nvalid, output int done_at);
    word = '0; first = 0; nvalid = 0; done_at = 0;
    for (int n = 1; n <= max_steps; n++) begin
      @(negedge clk);
      if (bit_valid) begin
        word = {word[14:0], bit_out};
        nvalid++;
        if (first == 0) first = n;
      end
      if (row_done && done_at == 0) done_at = n;
      if (stop_bits != 0 && nvalid == stop_bits) break;
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_bit_out"},   32'(bit_out),   32'd0);
    chk({name, "_bit_valid"}, 32'(bit_valid), 32'd0);
    chk({name, "_row_done"},  32'(row_done),  32'd0);
    chk({name, "_busy"},      32'(busy),      32'd0);
  endtask

  initial begin
    logic [15:0] w;
    int f, nv, d;

    // Reset with Addr=3, then release: 2-edge latency, 16 bits, done at 18.
    Addr = 5'd3;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    #1 rst_n = 1'b1;
    run(20, 0, w, f, nv, d);
    chk("r3_first", 32'(f), 32'd2);
    chk("r3_count", 32'(nv), 32'd16);
    chk("r3_word", 32'(w), 32'(exp3));
    chk("r3_done_at", 32'(d), 32'd18);
    chk("r3_done_sticky", 32'(row_done), 32'd1);

    // Addr=15 held 40 cycles: one burst, then idle in done.
    #1 Addr = 5'd15;
    run(40, 0, w, f, nv, d);
    chk("r15_first", 32'(f), 32'd2);
    chk("r15_count", 32'(nv), 32'd16);
    chk("r15_end_done", 32'(row_done), 32'd1);
    chk("r15_end_busy", 32'(busy), 32'd0);
    chk("r15_end_valid", 32'(bit_valid), 32'd0);

    // Abandon row 3 after 7 bits for row 24.
    #1 Addr = 5'd3;
    run(30, 7, w, f, nv, d);
    chk("r3p_count", 32'(nv), 32'd7);
    chk("r3p_bits", 32'(w[6:0]), 32'(exp3[15:9]));
    #1 Addr = 5'd24;
    run(20, 0, w, f, nv, d);
    chk("r24_first", 32'(f), 32'd2);
    chk("r24_count", 32'(nv), 32'd16);
    chk("r24_word", 32'(w), 32'(exp24));
    chk("r24_done_at", 32'(d), 32'd18);

    // Asynchronous reset (35 ns) mid-row, then full replay of row 3.
    #1 Addr = 5'd3;
    run(30, 5, w, f, nv, d);
    chk("pre_rst_count", 32'(nv), 32'd5);
    #1 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    #34 rst_n = 1'b1;
    @(negedge clk);
    chk_zero("post_rel");
    run(20, 0, w, f, nv, d);
    chk("rr3_first", 32'(f), 32'd2);
    chk("rr3_count", 32'(nv), 32'd16);
    chk("rr3_word", 32'(w), 32'(exp3));
    chk("rr3_done_at", 32'(d), 32'd18);

    // Addr change during the last bit: reload wins, no row_done.
    #1 Addr = 5'd17;
    run(30, 16, w, f, nv, d);
    chk("r17_count", 32'(nv), 32'd16);
    chk("r17_no_done", 32'(d), 32'd0);
    #1 Addr = 5'd18;
    run(20, 0, w, f, nv, d);
    chk("r18_first", 32'(f), 32'd2);
    chk("r18_count", 32'(nv), 32'd16);
    chk("r18_word", 32'(w), 32'(exp18));
    chk("r18_done_at", 32'(d), 32'd18);

    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/row_serializer.md
# row_serializer

Upstream feed stage for the overlapping sequence detector. Reads one DATA_W-bit row from an internal ROM at the address on `Addr` and presents it to the detector as a serial bit stream, one bit per clock, with a valid qualifier and a sticky end-of-row flag. A new row starts automatically after reset release or whenever `Addr` changes. The detector consumes `bit_out` only while `bit_valid` is high.

## Interface
- DATA_W, 16: bits per ROM row.
- ADDR_W, 5: address width.
- DEPTH, 32: number of ROM rows; must equal 2**ADDR_W.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- Addr  input  ADDR_W  row select; sampled every clock.
- bit_out  output  1  current serial bit; 0 whenever bit_valid is low.
- bit_valid  output  1  high for exactly DATA_W consecutive cycles per row.
- row_done  output  1  high from the cycle after the last bit until reload or reset.
- busy  output  1  high in LOAD and SHIFT.

## Operation
- States: IDLE, LOAD, SHIFT, DONE. Reset state is IDLE.
- IDLE -> LOAD on the first edge with rst_n high. Synchronous ROM read of Addr is issued; addr_q <= Addr.
- LOAD -> SHIFT: shreg <= ROM[addr_q], cnt <= 0.
- SHIFT: bit_out = shreg[DATA_W-1] (MSB first); on each edge shreg shifts left with 0 fill, and cnt increments. When cnt == DATA_W-1 -> DONE.
- DONE: holds. bit_valid = 0, row_done = 1.
- Addr change: when Addr != addr_q in LOAD, SHIFT or DONE, the next state is LOAD and addr_q <= Addr. The partial row is abandoned, bit_valid drops that edge, and row_done clears. This takes priority over the cnt terminal transition.
- cnt is $clog2(DATA_W)+1 bits wide and never wraps within a row.
- Reset mid-row: all state clears immediately (asynchronous). After release the row restarts from its first bit.

## Timing
- Reset values: bit_out=0, bit_valid=0, row_done=0, busy=0, shreg=0, cnt=0, addr_q=0.
- Edge E1 (first edge with rst_n high): LOAD. Edge E2: SHIFT, and the first bit is valid after E2. The last bit is valid after E(DATA_W+1). DONE and row_done are set after E(DATA_W+2).
- Latency from reset release to first valid bit: 2 edges. Row period: DATA_W+2 cycles.
- Addr change sampled at edge Ek: LOAD after Ek, first bit of the new row valid after Ek+1.
- All outputs are registered or decoded from state only. No combinational path from Addr to any output.

## Configuration
- SER_LSB_FIRST_EN defined: the row is emitted LSB first. shreg shifts right and bit_out = shreg[0].
- Not defined: MSB first, as described above.
- Cycle timing is identical in both builds.

## Structure
- Package `seq_pkg` holds:
  - DATA_W, ADDR_W and DEPTH defaults.
  - The state enum typedef (ser_state_t).
  - ROW_DATA: the DEPTH x DATA_W ROM contents constant, shared with the detector bench.
- Sub-module `row_rom`: synchronous-read ROM initialised from ROW_DATA, with one read port (addr, data registered on clk).

## Test plan
- Reset release with Addr=3 -> bit_valid high for 16 cycles starting after the 2nd edge, and the bit stream equals ROW_DATA[3] MSB first. row_done rises after the 18th edge and stays high.
- Addr=15 held 40 cycles -> exactly one 16-bit burst, then bit_valid=0, row_done=1, busy=0 for the remainder.
- Addr changed 3 -> 24 after 7 bits of row 3 -> bit_valid drops next cycle, then the full 16 bits of ROW_DATA[24] appear with no leftover row-3 bits.
- rst_n pulsed low for 35 ns mid-row -> all outputs 0 immediately (asynchronous). After release the row replays from bit 0 with 2-edge latency.
- Addr changed in the same cycle as the last bit -> reload wins, row_done never asserts, and the new row starts.
- Build with SER_LSB_FIRST_EN, Addr=3 -> the stream equals ROW_DATA[3] bit 0 first, with identical cycle timing.
